// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - dispatch, writeback and commit signals between the core and the reorder buffer
interface reorder_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int TAG_W = $clog2(DEPTH);

  logic             flush;
  logic             alloc_valid;
  logic             alloc_has_dest;
  logic [1:0]       alloc_dest;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [7:0]       wb_data;
  logic [1:0]       write_register;
  logic [7:0]       write_data;
  logic             reg_write_enable;
  logic             retire_valid;
  logic [TAG_W:0]   count;

  modport master (
    output flush, alloc_valid, alloc_has_dest, alloc_dest, wb_valid, wb_tag, wb_data,
    input  alloc_ready, alloc_tag, write_register, write_data, reg_write_enable,
           retire_valid, count
  );

  modport slave (
    input  flush, alloc_valid, alloc_has_dest, alloc_dest, wb_valid, wb_tag, wb_data,
    output alloc_ready, alloc_tag, write_register, write_data, reg_write_enable,
           retire_valid, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit stage feeding the register file write port
module reorder_buffer #(
  parameter  int DEPTH = 4,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  bus
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_has_dest;
  logic [1:0]       r_dest [DEPTH];
  logic [7:0]       r_data [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;
  logic             r_retire;
  logic             r_we;
  logic [1:0]       r_wreg;
  logic [7:0]       r_wdata;

  logic             w_alloc_ready;
  logic             w_alloc;
  logic             w_wb;
  logic             w_commit;
  logic [TAG_W:0]   w_count_next;

  // Occupancy comes from the counter, so head==tail is never ambiguous.
  assign w_alloc_ready = (r_count < (TAG_W+1)'(DEPTH));
  assign w_alloc       = bus.alloc_valid && w_alloc_ready;
  assign w_wb          = bus.wb_valid && r_valid[bus.wb_tag] && !r_done[bus.wb_tag];
  assign w_commit      = r_valid[r_head] && r_done[r_head];

  always_comb begin
    w_count_next = r_count;
    if (w_alloc && !w_commit) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_alloc && w_commit) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_done   <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_retire <= 1'b0;
      r_we     <= 1'b0;
      r_wreg   <= '0;
      r_wdata  <= '0;
    end else if (bus.flush) begin
      r_valid  <= '0;
      r_done   <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_retire <= 1'b0;
      r_we     <= 1'b0;
    end else begin
      // Commit, writeback and allocate always touch distinct entries.
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + 1'b1;
        r_wreg          <= r_dest[r_head];
        r_wdata         <= r_data[r_head];
      end
      if (w_wb) begin
        r_done[bus.wb_tag] <= 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + 1'b1;
      end
      r_count  <= w_count_next;
      r_retire <= w_commit;
      r_we     <= w_commit && r_has_dest[r_head];
    end
  end

  // Payload fields are qualified by r_valid/r_done and need no reset.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      if (w_alloc) begin
        r_has_dest[r_tail] <= bus.alloc_has_dest;
        r_dest[r_tail]     <= bus.alloc_dest;
      end
      if (w_wb) begin
        r_data[bus.wb_tag] <= bus.wb_data;
      end
    end
  end

  assign bus.alloc_ready      = w_alloc_ready;
  assign bus.alloc_tag        = r_tail;
  assign bus.count            = r_count;
  assign bus.retire_valid     = r_retire;
  assign bus.reg_write_enable = r_we;
  assign bus.write_register   = r_wreg;
  assign bus.write_data       = r_wdata;

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order commit stage of the 8-bit out-of-order core. It sits directly upstream of the 4-entry, 8-bit register file's write port. It allocates entries in program order at dispatch and accepts out-of-order writeback results tagged by entry. It retires completed entries strictly in order, driving the register file's `write_register`, `write_data` and `reg_write_enable` inputs.

## Interface
- `DEPTH`, 4: number of ROB entries. Must be a power of two, at least 2.
- `TAG_W`, `$clog2(DEPTH)`: entry tag width. Derived; do not override.

- `clk`: input, 1. Single clock, rising edge.
- `rst`: input, 1. Synchronous, active-high reset.
- `flush`: input, 1. Synchronous; discards all entries.
- `alloc_valid`: input, 1. Dispatch requests an entry.
- `alloc_has_dest`: input, 1. The instruction writes a register.
- `alloc_dest`: input, 2. Destination register index.
- `alloc_ready`: output, 1. An entry is free (`count < DEPTH`).
- `alloc_tag`: output, TAG_W. Tag that the current allocation receives (the tail pointer).
- `wb_valid`: input, 1. Execution result is valid.
- `wb_tag`: input, TAG_W. Entry being completed.
- `wb_data`: input, 8. Result value.
- `write_register`: output, 2. To register file `write_register`.
- `write_data`: output, 8. To register file `write_data`.
- `reg_write_enable`: output, 1. To register file `reg_write_enable`.
- `retire_valid`: output, 1. One-cycle pulse per retired entry, including entries with no destination.
- `count`: output, TAG_W+1. Number of occupied entries.

## Operation
- **Entry state:** `valid`, `done`, `has_dest`, `dest[1:0]`, `data[7:0]`.
- **Pointers:** `head` and `tail` are TAG_W bits and wrap modulo DEPTH. Full and empty are decided from `count`, not from pointer compare.
- **Allocate:** when `alloc_valid && alloc_ready`, set entry[`tail`] to `valid=1`, `done=0`, and latch `has_dest`/`dest`. Then `tail` increments. If `alloc_valid` is high while full, the request is ignored and no state changes.
- **Writeback:** when `wb_valid` targets an entry with `valid=1` and `done=0`, set `done=1` and `data=wb_data`. Writeback to an invalid entry, or to one already done, is ignored.
- **Commit:** evaluated each cycle on the registered state. If entry[`head`] has `valid && done`:
  - At the edge, clear the entry and increment `head`.
  - Register `retire_valid=1`.
  - Register `reg_write_enable=has_dest`, `write_register=dest` and `write_data=data`.
  - Otherwise the commit outputs register as `retire_valid=0` and `reg_write_enable=0`; `write_register` and `write_data` hold their values.
  - At most one commit per cycle.
- **Count:** increments on allocate only, decrements on commit only, and is unchanged when both happen in the same cycle.
- **Simultaneous events:** allocate, writeback and commit may all occur in one cycle to different entries.
  - Writeback to the head entry in cycle N is not visible to commit until cycle N+1; there is no same-cycle bypass.
  - `alloc_ready` depends only on the registered `count`, not on a same-cycle commit.
- **Flush:** priority is `rst` > `flush` > normal operation.
  - Flush clears every `valid` and `done`.
  - `head`, `tail` and `count` become 0.
  - Next-cycle `retire_valid` and `reg_write_enable` are 0.
  - Allocation and writeback presented in the flush cycle are discarded.
- **Reset:** applies the same state as flush, plus `write_register=0` and `write_data=0`.

## Timing
- **Reset values:** `alloc_ready=1`, `alloc_tag=0`, `count=0`, `write_register=0`, `write_data=0`, `reg_write_enable=0`, `retire_valid=0`.
- **Combinational outputs:** `alloc_ready` and `alloc_tag` are combinational from registered state. All commit outputs are registered.
- **Latency:**
  - Allocate in cycle N: the entry is occupied from cycle N+1.
  - Writeback in cycle N, with the entry at head: `done` is set from N+1, and `reg_write_enable` is high in cycle N+2.
  - The register file captures the write at the end of N+2, so the new value is readable in N+3.
- **Throughput:** one allocation and one retirement per cycle sustained.
- **Reset mid-operation:** asserting `rst` in any cycle makes all state and outputs take reset values from the next cycle. No partial commit is emitted.

## Test plan
- **Reset then allocate to full:** after `rst`, allocate 4 entries with dest 0..3 and no writeback. Required: `alloc_tag` sequence 0,1,2,3; `count`=4; `alloc_ready`=0; a 5th `alloc_valid` leaves `count`=4 and `tail` unchanged.
- **Out-of-order writeback:** with 3 entries (dest 1,2,3), write back tag 2 (0x33), then tag 1 (0x22), then tag 0 (0x11) on consecutive cycles. Required: no commit until tag 0 completes; then `reg_write_enable` is high for 3 consecutive cycles with (reg,data) = (1,0x11), (2,0x22), (3,0x33); `count` reaches 0.
- **No-destination entry:** allocate with `alloc_has_dest=0`, write back 0xAA. Required: one cycle with `retire_valid=1` and `reg_write_enable=0`; register file contents unchanged.
- **Wrap-around with simultaneous allocate and commit:** run 10 instructions through with `alloc_valid` held high while committing. Required: `alloc_tag` wraps 3→0; `count` stays constant while alloc and commit overlap; commit order matches allocation order.
- **Flush mid-stream:** with 3 entries, 1 done and at head, assert `flush` in the same cycle as a writeback to tag 1. Required: no commit follows; `count`=0 and `alloc_tag`=0 next cycle; a later writeback to tag 1 is ignored.
- **Ignored writebacks:** send a writeback to an empty slot, then a second writeback (0x55) to an already-done entry holding 0x44. Required: no state change; the commit writes 0x44.
